// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code capture path and its gray_to_binary consumer.
package gray_pkg;

    localparam int GRAY_WIDTH  = 4;
    localparam int GRAY_MAX_W  = 64;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } gsc_state_e;

    // Hamming distance between two Gray words; callers zero-extend to GRAY_MAX_W.
    function automatic int unsigned gray_step_dist(input logic [GRAY_MAX_W-1:0] a,
                                                   input logic [GRAY_MAX_W-1:0] b);
        logic [GRAY_MAX_W-1:0] diff;
        int unsigned           cnt;
        diff = a ^ b;
        cnt  = 0;
        for (int i = 0; i < GRAY_MAX_W; i++) begin
            cnt = cnt + int'(diff[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchronizer for an asynchronous Gray word; the only sampler of the async input.
module gray_sync_chain #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync_capture.sv
// Synchronizes an async Gray word, detects changes and presents them on a 1-entry valid/ready
// register (newest wins). Step checking is built only when GRAY_SYNC_STEP_CHECK_EN is defined.
module gray_sync_capture
    import gray_pkg::*;
#(
    parameter int WIDTH       = GRAY_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     gray_async_i,
    input  logic                 en,
    output logic [WIDTH-1:0]     gray_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 overrun_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);

    logic [WIDTH-1:0]  sync_q;
    logic [WIDTH-1:0]  last_q;
    logic [FILL_W-1:0] fill_cnt;
    logic              primed;
    logic              filled;
    logic              prime_ld;
    logic              chg_evt;
    logic              load;
    gsc_state_e        state;

    gray_sync_chain #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gray_async_i),
        .q   (sync_q)
    );

    // The chain holds reset zeros until it has been clocked SYNC_STAGES times.
    assign filled   = (fill_cnt == FILL_W'(SYNC_STAGES));
    assign prime_ld = filled & ~primed & en;
    assign chg_evt  = primed & en & (sync_q != last_q);
    assign load     = prime_ld | chg_evt;
    assign valid_o  = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= '0;
            primed   <= 1'b0;
            last_q   <= '0;
        end else begin
            if (!filled) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
            if (prime_ld) begin
                primed <= 1'b1;
            end
            if (load) begin
                last_q <= sync_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            gray_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= load & (state == FULL) & ~ready_i;
            if (load) begin
                gray_o <= sync_q;
                state  <= FULL;
            end else if ((state == FULL) && ready_i) begin
                state <= EMPTY;
            end
        end
    end

`ifdef GRAY_SYNC_STEP_CHECK_EN
    logic illegal;

    // Baseline loads never count; only true change events are checked.
    assign illegal = chg_evt &
                     (gray_step_dist(GRAY_MAX_W'(sync_q), GRAY_MAX_W'(last_q)) > 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            err_o <= illegal;
            if (illegal && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            end
        end
    end
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_gray_sync_capture.sv
// Randomized and directed bench for gray_sync_capture against a queue-based reference model.
module tb_gray_sync_capture;

    localparam int WIDTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ERR_CNT_W   = 8;
    localparam int ERR_MAX     = (1 << ERR_CNT_W) - 1;
`ifdef GRAY_SYNC_STEP_CHECK_EN
    localparam bit STEP_CHK = 1'b1;
`else
    localparam bit STEP_CHK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [WIDTH-1:0]     gray_async_i = '0;
    logic                 en = 1'b0;
    logic                 ready_i = 1'b0;
    logic [WIDTH-1:0]     gray_o;
    logic                 valid_o;
    logic                 overrun_o;
    logic                 err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    gray_sync_capture #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .ERR_CNT_W   (ERR_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gray_async_i (gray_async_i),
        .en           (en),
        .gray_o       (gray_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .overrun_o    (overrun_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a delay line of input samples plus word/handshake bookkeeping.
    logic [WIDTH-1:0] m_pipe[$];
    int               m_age;
    bit               m_primed;
    bit               m_full;
    bit               m_ovr;
    bit               m_err;
    logic [WIDTH-1:0] m_word;
    logic [WIDTH-1:0] m_base;
    int               m_errs;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            b[i] = g[i] ^ ((i == WIDTH - 1) ? 1'b0 : b[i+1]);
        end
        return b;
    endfunction

    task automatic model_reset();
        m_pipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) m_pipe.push_back('0);
        m_age    = 0;
        m_primed = 0;
        m_full   = 0;
        m_ovr    = 0;
        m_err    = 0;
        m_word   = '0;
        m_base   = '0;
        m_errs   = 0;
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] seen;
        bit               is_new;
        seen   = m_pipe[SYNC_STAGES-1];
        is_new = 0;
        m_ovr  = 0;
        m_err  = 0;
        if (m_age >= SYNC_STAGES && en) begin
            if (!m_primed) begin
                is_new   = 1;
                m_primed = 1;
            end else if (seen != m_base) begin
                is_new = 1;
                if (STEP_CHK && $countones(seen ^ m_base) > 1) begin
                    m_err = 1;
                    if (m_errs < ERR_MAX) m_errs++;
                end
            end
        end
        if (is_new) begin
            if (m_full && !ready_i) m_ovr = 1;
            m_word = seen;
            m_base = seen;
            m_full = 1;
        end else if (m_full && ready_i) begin
            m_full = 0;
        end
        m_pipe.push_front(gray_async_i);
        void'(m_pipe.pop_back());
        m_age++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("valid", 32'(valid_o), 32'(m_full));
        check_val("gray", 32'(gray_o), 32'(m_word));
        check_val("overrun", 32'(overrun_o), 32'(m_ovr));
        check_val("err", 32'(err_o), 32'(m_err));
        check_val("err_cnt", 32'(err_cnt_o), 32'(m_errs));
    endtask

    // Called at a falling edge; checks the asynchronous clear before any rising edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_gray", 32'(gray_o), 32'd0);
        check_val("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic hold(input logic [WIDTH-1:0] code, input int n);
        gray_async_i = code;
        repeat (n) cycle();
    endtask

    logic [WIDTH-1:0] cur;

    initial begin
        model_reset();
        en      = 1'b1;
        ready_i = 1'b1;
        @(negedge clk);
        do_reset();

        // Gray walk with single-bit steps, fixed latency of 3 edges.
        hold(4'b0000, 4);
        for (int i = 1; i < 4; i++) begin
            gray_async_i = WIDTH'(i ^ (i >> 1));
            repeat (3) cycle();
            check_val("walk_latency", 32'(gray_o), 32'(i ^ (i >> 1)));
            cycle();
        end

        // Stall: second word overwrites the first, then a single drain.
        hold(4'b0011, 1);
        hold(4'b0001, 1);
        hold(4'b0000, 4);
        ready_i = 1'b0;
        hold(4'b0001, 1);
        hold(4'b0011, 4);
        check_val("stall_word", 32'(gray_o), 32'h3);
        check_val("stall_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        cycle();
        check_val("drain_empty", 32'(valid_o), 32'd0);
        cycle();

        // Illegal steps and counter saturation.
        hold(4'b0001, 4);
        hold(4'b0000, 4);
        hold(4'b0110, 4);
        check_val("illegal_word", 32'(gray_o), 32'h6);
        check_val("illegal_cnt", 32'(err_cnt_o), STEP_CHK ? 32'd1 : 32'd0);
        for (int i = 0; i < 300; i++) begin
            ready_i = 1'($urandom_range(0, 1));
            hold((i % 2 == 0) ? 4'b0000 : 4'b0110, 1);
        end
        ready_i = 1'b1;
        repeat (4) cycle();
        check_val("sat_cnt", 32'(err_cnt_o), STEP_CHK ? 32'(ERR_MAX) : 32'd0);

        // Baseline held through reset release, then en=0 blocks events.
        gray_async_i = 4'b1010;
        do_reset();
        repeat (3) cycle();
        check_val("baseline_word", 32'(gray_o), 32'ha);
        check_val("baseline_valid", 32'(valid_o), 32'd1);
        check_val("baseline_err", 32'(err_o), 32'd0);
        en = 1'b0;
        for (int i = 0; i < 12; i++) hold(WIDTH'($urandom), 1);
        check_val("en_off_valid", 32'(valid_o), 32'd0);
        en = 1'b1;
        repeat (4) cycle();

        // Reset while a word is held.
        ready_i      = 1'b0;
        gray_async_i = 4'b0111;
        do_reset();
        repeat (4) cycle();
        check_val("full_0111", 32'(gray_o), 32'h7);
        do_reset();
        repeat (4) cycle();
        ready_i = 1'b1;
        repeat (2) cycle();

        // Full code sweep through the Gray-to-binary mapping.
        gray_async_i = '0;
        do_reset();
        repeat (4) cycle();
        for (int i = 0; i < 16; i++) begin
            gray_async_i = WIDTH'(i ^ (i >> 1));
            repeat (3) cycle();
            check_val("sweep_bin", 32'(g2b(gray_o)), 32'(i));
            cycle();
        end

        // Random traffic: mostly single-bit steps, occasional jumps, enable and reset noise.
        cur = gray_async_i;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            en      = ($urandom_range(0, 7) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2:    cur = WIDTH'($urandom);
                3, 4, 5, 6: cur = cur ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default:    ;
            endcase
            hold(cur, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
